// File: rtl/t80_memarb.sv
// ============================================================================
//  Module   : t80_memarb
//  Purpose  : Single-port SRAM arbiter between the T80 core and the host CPU,
//             with wait states, fixed/round-robin priority and a T80
//             write-protected low region.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module t80_memarb #(
  parameter int asz         = 11,
  parameter int dsz         = 8,
  parameter int wait_states = 0,
  parameter int prio_mode   = 0,
  parameter int rom_top     = 0
) (
  input  logic           clk250,
  input  logic           reset,
  input  logic           mem_req,
  input  logic           mem_rd,
  input  logic [asz-1:0] addr,
  input  logic [dsz-1:0] ram_wdata,
  output logic           mem_ack,
  output logic [dsz-1:0] ram_rdata,
  input  logic           cpu_t80_mem_req,
  input  logic           cpu_t80_mem_read,
  input  logic [asz-1:0] cpu_t80_addr,
  input  logic [dsz-1:0] cpu_t80_mem_wdata,
  output logic           t80_cpu_mem_ack,
  output logic [dsz-1:0] t80_cpu_mem_rdata,
  output logic           sram_cs,
  output logic           sram_we,
  output logic [asz-1:0] sram_addr,
  output logic [dsz-1:0] sram_wd,
  input  logic [dsz-1:0] sram_rd,
  output logic           wp_viol
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCESS = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_LATCH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] c_wait    = 4'(wait_states);
  localparam logic [asz:0] c_rom_top = (asz+1)'(rom_top);

  logic [2:0]     r_state;
  logic [3:0]     r_wcnt;
  logic           r_gnt_host;
  logic           r_last_host;
  logic           r_host_armed;
  logic           r_rd;
  logic           r_blocked;
  logic [asz-1:0] r_addr;
  logic [dsz-1:0] r_wdata;
  logic [dsz-1:0] r_ram_rdata;
  logic [dsz-1:0] r_host_rdata;

  logic w_t80_pend;
  logic w_host_pend;
  logic w_pick_host;
  logic w_t80_blocked;

  always_comb begin
    w_t80_pend    = mem_req;
    w_host_pend   = cpu_t80_mem_req & r_host_armed;
    w_t80_blocked = ~mem_rd & ({1'b0, addr} < c_rom_top);
    // On a tie, round-robin favours whoever did not win the previous grant.
    if (w_t80_pend && w_host_pend)
      w_pick_host = (prio_mode != 0) ? ~r_last_host : 1'b0;
    else
      w_pick_host = w_host_pend;
  end

  always_ff @(posedge clk250) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wcnt       <= 4'd0;
      r_gnt_host   <= 1'b0;
      r_last_host  <= 1'b1;
      r_host_armed <= 1'b1;
      r_rd         <= 1'b0;
      r_blocked    <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ram_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      if (!cpu_t80_mem_req)
        r_host_armed <= 1'b1;
      else if (r_state == S_IDLE && w_host_pend && w_pick_host)
        r_host_armed <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_t80_pend || w_host_pend) begin
            r_gnt_host  <= w_pick_host;
            r_last_host <= w_pick_host;
            r_addr      <= w_pick_host ? cpu_t80_addr      : addr;
            r_wdata     <= w_pick_host ? cpu_t80_mem_wdata : ram_wdata;
            r_rd        <= w_pick_host ? cpu_t80_mem_read  : mem_rd;
            r_blocked   <= ~w_pick_host & w_t80_blocked;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (c_wait == 4'd0) begin
            r_state <= S_LATCH;
          end else begin
            r_wcnt  <= c_wait - 4'd1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wcnt == 4'd0)
            r_state <= S_LATCH;
          else
            r_wcnt <= r_wcnt - 4'd1;
        end
        S_LATCH: begin
          if (r_rd) begin
            if (r_gnt_host)
              r_host_rdata <= sram_rd;
            else
              r_ram_rdata  <= sram_rd;
          end
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A blocked write still strobes the SRAM, but only as a harmless read.
  assign sram_cs           = (r_state == S_ACCESS);
  assign sram_we           = sram_cs & ~r_rd & ~r_blocked;
  assign sram_addr         = sram_cs ? r_addr  : '0;
  assign sram_wd           = sram_cs ? r_wdata : '0;
  assign mem_ack           = (r_state == S_DONE) & ~r_gnt_host;
  assign t80_cpu_mem_ack   = (r_state == S_DONE) &  r_gnt_host;
  assign wp_viol           = (r_state == S_DONE) &  r_blocked;
  assign ram_rdata         = r_ram_rdata;
  assign t80_cpu_mem_rdata = r_host_rdata;

endmodule

`default_nettype wire
